lsu: RTL
========

# lsu

Per-thread load/store unit for the GPU core's memory stage. It sits directly downstream of the per-thread register file and takes RS1 as the address and RS2 as the store data. It runs a valid/ready transaction with the data-memory controller and returns loaded data on `lsu_out`, which the writeback mux routes to the register file's `WD`. The scheduler uses `lsu_state` to stall the pipeline until every thread's LSU reaches DONE.

## Interface
- `DATA_WIDTH`, 16: width of register data, memory data and `lsu_out`.
- `ADDR_WIDTH`, 8: data-memory address width. The address is `rs1[ADDR_WIDTH-1:0]`; upper bits are ignored.

Ports:
- `clk`, input, 1: single clock. All state changes on the rising edge.
- `reset`, input, 1: **asynchronous, active-high reset.**
- `enable`, input, 1: thread is active. Sampled only in IDLE.
- `issue`, input, 1: one-cycle pulse; the instruction is in the memory stage.
- `mem_read_en`, input, 1: decoded LDR.
- `mem_write_en`, input, 1: decoded STR.
- `rs1`, input, DATA_WIDTH: address operand from the register file.
- `rs2`, input, DATA_WIDTH: store-data operand from the register file.
- `retire`, input, 1: scheduler acknowledges completion. Returns DONE to IDLE.
- `mem_read_valid`, output, 1: read request.
- `mem_read_address`, output, ADDR_WIDTH: read address.
- `mem_read_ready`, input, 1: read accepted; `mem_read_data` is valid in the same cycle.
- `mem_read_data`, input, DATA_WIDTH: read return data.
- `mem_write_valid`, output, 1: write request.
- `mem_write_address`, output, ADDR_WIDTH: write address.
- `mem_write_data`, output, DATA_WIDTH: write data.
- `mem_write_ready`, input, 1: write accepted.
- `lsu_state`, output, 2: IDLE=2'b00, REQUESTING=2'b01, DONE=2'b11.
- `lsu_out`, output, DATA_WIDTH: last loaded value.

## Operation
- All outputs are registered.
- **Reset values:** state IDLE, both valids 0, both addresses 0, `mem_write_data` 0, `lsu_out` 0.
- **IDLE:**
  - Accept when `issue && enable && (mem_read_en || mem_write_en)`.
  - On acceptance: latch `rs1[ADDR_WIDTH-1:0]` into the address register of the selected port and go to REQUESTING.
  - A write also latches `rs2` into `mem_write_data`.
  - If both enables are set, the read wins. No write is issued for that instruction.
  - Otherwise stay in IDLE.
- **REQUESTING:**
  - Hold the selected valid high until its ready is sampled high.
  - Read: on the edge where `mem_read_ready`=1, capture `mem_read_data` into `lsu_out`, clear `mem_read_valid`, go to DONE.
  - Write: on the edge where `mem_write_ready`=1, clear `mem_write_valid`, go to DONE. `lsu_out` is unchanged.
  - Address and data are stable throughout the request.
  - `issue`, `enable`, `rs1` and `rs2` are ignored; the transaction is never abandoned.
  - Ready on the non-selected port is ignored.
- **DONE:**
  - Hold until `retire`=1, then go to IDLE.
  - `issue` is ignored in DONE; a simultaneous `retire` and `issue` goes to IDLE only.
- `retire` is ignored outside DONE.
- The unused encoding 2'b10 goes to IDLE with both valids cleared.
- `lsu_out` holds its value across stores, retire and idle. Only a completed load or reset changes it.

## Timing
- Edges are numbered E0 = first edge with `issue` high.
- **E0:** state goes to REQUESTING. The valid and address are visible in the cycle after E0.
- **First sampling edge:** E1. With ready held high, E1 moves the state to DONE and drops the valid; `lsu_out` updates after E1.
- **Minimum latency:** issue to DONE is 2 edges. Each stall cycle (ready low) adds one edge.
- **Retire:** `retire` at edge En moves the state to IDLE after En. A new `issue` is accepted at En+1 at the earliest.
- **Reset in REQUESTING:** asserting reset drops the valid in the same cycle, asynchronously. No capture occurs. State is IDLE while reset is held.
- **Reset release:** the first accept is on the first edge with reset low.

## Test plan
- **Load, no stall.** Reset, then `rs1`=16'h1234, `mem_read_en`=1, `issue` pulse; `mem_read_ready`=1 with `mem_read_data`=16'hBEEF.
  -> After E0: `mem_read_address`=8'h34, valid=1.
  -> After E1: state DONE, `lsu_out`=16'hBEEF, valid=0.
- **Load with 3-cycle stall.** Ready low for E1–E3, high at E4.
  -> Valid and address stay stable through E4; DONE after E4.
  -> `retire` at E5 gives IDLE.
- **Store.** `rs1`=16'h0010, `rs2`=16'hCAFE, `mem_write_en`=1; `mem_write_ready` high at E2.
  -> Write address 8'h10 and data 16'hCAFE held until E2; DONE after E2.
  -> `lsu_out` unchanged from its prior value.
- **Both enables set.** `mem_read_en`=1 and `mem_write_en`=1 with `issue`.
  -> Only `mem_read_valid` asserts; `mem_write_valid` stays 0 throughout.
- **Ignored issue while busy.** Second `issue` with a new `rs1` during REQUESTING and during DONE.
  -> Address unchanged; no new transaction.
  -> `enable`=0 with `issue` in IDLE leaves the state at IDLE.
- **Reset mid-request.** Assert reset asynchronously in REQUESTING.
  -> `mem_read_valid`=0 immediately, state IDLE, `lsu_out`=0.
  -> Load accepted on the first edge after release.

Source files
------------

// File: rtl/lsu.sv
// lsu: per-thread load/store unit driving a valid/ready data-memory port and returning loads on lsu_out
module lsu #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  issue,
  input  logic                  mem_read_en,
  input  logic                  mem_write_en,
  input  logic [DATA_WIDTH-1:0] rs1,
  input  logic [DATA_WIDTH-1:0] rs2,
  input  logic                  retire,
  output logic                  mem_read_valid,
  output logic [ADDR_WIDTH-1:0] mem_read_address,
  input  logic                  mem_read_ready,
  input  logic [DATA_WIDTH-1:0] mem_read_data,
  output logic                  mem_write_valid,
  output logic [ADDR_WIDTH-1:0] mem_write_address,
  output logic [DATA_WIDTH-1:0] mem_write_data,
  input  logic                  mem_write_ready,
  output logic [1:0]            lsu_state,
  output logic [DATA_WIDTH-1:0] lsu_out
);
  typedef enum logic [1:0] {IDLE = 2'b00, REQUESTING = 2'b01, UNUSED = 2'b10, DONE = 2'b11} state_t;
  state_t state;
  assign lsu_state = state;
  // the asserted valid doubles as the record of which port the pending request uses
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state             <= IDLE;
      mem_read_valid    <= 1'b0;
      mem_read_address  <= '0;
      mem_write_valid   <= 1'b0;
      mem_write_address <= '0;
      mem_write_data    <= '0;
      lsu_out           <= '0;
    end else
      case (state)
        IDLE:
          if (issue && enable && (mem_read_en || mem_write_en)) begin
            state <= REQUESTING;
            if (mem_read_en) begin
              mem_read_valid   <= 1'b1;
              mem_read_address <= rs1[ADDR_WIDTH-1:0];
            end else begin
              mem_write_valid   <= 1'b1;
              mem_write_address <= rs1[ADDR_WIDTH-1:0];
              mem_write_data    <= rs2;
            end
          end
        REQUESTING:
          if (mem_read_valid) begin
            if (mem_read_ready) begin
              lsu_out        <= mem_read_data;
              mem_read_valid <= 1'b0;
              state          <= DONE;
            end
          end else if (mem_write_valid) begin
            if (mem_write_ready) begin
              mem_write_valid <= 1'b0;
              state           <= DONE;
            end
          end else
            state <= IDLE;
        DONE:
          if (retire) state <= IDLE;
        default: begin
          state           <= IDLE;
          mem_read_valid  <= 1'b0;
          mem_write_valid <= 1'b0;
        end
      endcase
endmodule
